ab_input_conditioner: RTL and testbench

- Upstream stage of the three-state S0/S1/S2 controller. Conditions the raw asynchronous inputs a_raw/b_raw into clean, synchronous, debounced levels a/b for the next-state logic.
- Also produces single-cycle rising-edge strobes, and a settled flag that the state register uses as its load enable.
- Two identical independent channels plus a shared startup timer.

---
 rtl/ab_cond_pkg.sv | 29 ++
 rtl/ab_input_conditioner_debounce_chan.sv | 71 +++++++
 rtl/ab_input_conditioner.sv | 92 +++++++++
 tb/tb_ab_input_conditioner.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ab_cond_pkg.sv
// Shared defaults, channel output bundle and parameter legality check
// for the a/b input conditioner.
package ab_cond_pkg;

  localparam int CNT_W_DEFAULT           = 16;
  localparam int DEBOUNCE_CYCLES_DEFAULT = 50000;

  typedef struct packed {
    logic level;
    logic rise;
  } chan_out_t;

  // Counters must hold DEBOUNCE_CYCLES+2 without wrapping.
  function automatic bit params_legal(input int debounce_cycles, input int cnt_w);
    bit ok;
    ok = 1'b1;
    if ((cnt_w < 2) || (cnt_w > 31)) begin
      ok = 1'b0;
    end else if (debounce_cycles < 1) begin
      ok = 1'b0;
    end else if ((longint'(debounce_cycles) + 64'sd2) >= (64'sd1 <<< cnt_w)) begin
      ok = 1'b0;
    end else begin
      ok = 1'b1;
    end
    return ok;
  endfunction

endpackage

// File: rtl/ab_input_conditioner_debounce_chan.sv
// One conditioning channel: two-flop synchronizer, restart-on-agreement
// debounce counter, registered level and qualified rising-edge strobe.
module debounce_chan
  import ab_cond_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
  parameter int CNT_W           = CNT_W_DEFAULT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  input  logic en_strobe,
  output logic level,
  output logic rise
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] ZERO_CNT = {CNT_W{1'b0}};

  logic             sync1_r;
  logic             sync2_r;
  logic             level_r;
  logic             rise_r;
  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] cnt_nxt_s;
  logic             level_nxt_s;
  logic             rise_nxt_s;

  // Plain two-flop synchronizer on the raw asynchronous input
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_r <= 1'b0;
      sync2_r <= 1'b0;
    end else begin
      sync1_r <= raw;
      sync2_r <= sync1_r;
    end
  end

  // Debounce next state: any agreeing cycle restarts the count, so cnt caps at LAST_CNT
  always_comb begin
    cnt_nxt_s   = cnt_r;
    level_nxt_s = level_r;
    if (sync2_r == level_r) begin
      cnt_nxt_s = ZERO_CNT;
    end else if (cnt_r == LAST_CNT) begin
      level_nxt_s = sync2_r;
      cnt_nxt_s   = ZERO_CNT;
    end else begin
      cnt_nxt_s = cnt_r + 1'b1;
    end
    rise_nxt_s = en_strobe & ~level_r & level_nxt_s;
  end

  // Counter, level and strobe registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r   <= ZERO_CNT;
      level_r <= 1'b0;
      rise_r  <= 1'b0;
    end else begin
      cnt_r   <= cnt_nxt_s;
      level_r <= level_nxt_s;
      rise_r  <= rise_nxt_s;
    end
  end

  assign level = level_r;
  assign rise  = rise_r;

endmodule

// File: rtl/ab_input_conditioner.sv
// Top of the a/b input conditioner: two debounce channels plus the shared
// startup timer whose sticky settled flag gates the rise strobes.
module ab_input_conditioner
  import ab_cond_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
  parameter int CNT_W           = CNT_W_DEFAULT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic a_raw,
  input  logic b_raw,
  output logic a,
  output logic b,
  output logic a_rise,
  output logic b_rise,
  output logic settled
);

  if (!params_legal(DEBOUNCE_CYCLES, CNT_W)) begin : g_bad_params
    $error("ab_input_conditioner: illegal DEBOUNCE_CYCLES/CNT_W combination");
  end

  // settled lands on the (DEBOUNCE_CYCLES+2)th edge, i.e. when the count moves from +1 to +2.
  localparam logic [CNT_W-1:0] SETTLE_CNT = CNT_W'(DEBOUNCE_CYCLES + 2);
  localparam logic [CNT_W-1:0] SETTLE_PRE = CNT_W'(DEBOUNCE_CYCLES + 1);

  logic [CNT_W-1:0] start_cnt_r;
  logic [CNT_W-1:0] start_cnt_nxt_s;
  logic             settled_r;
  logic             settled_nxt_s;
  chan_out_t        chan_a_s;
  chan_out_t        chan_b_s;

  // Startup timer next state: saturating edge count and sticky settled flag
  always_comb begin
    start_cnt_nxt_s = start_cnt_r;
    settled_nxt_s   = settled_r;
    if (start_cnt_r == SETTLE_CNT) begin
      start_cnt_nxt_s = start_cnt_r;
    end else begin
      start_cnt_nxt_s = start_cnt_r + 1'b1;
    end
    if (start_cnt_r == SETTLE_PRE) begin
      settled_nxt_s = 1'b1;
    end else begin
      settled_nxt_s = settled_r;
    end
  end

  // Startup timer registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      start_cnt_r <= {CNT_W{1'b0}};
      settled_r   <= 1'b0;
    end else begin
      start_cnt_r <= start_cnt_nxt_s;
      settled_r   <= settled_nxt_s;
    end
  end

  debounce_chan #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .CNT_W           (CNT_W)
  ) u_chan_a (
    .clk       (clk),
    .rst_n     (rst_n),
    .raw       (a_raw),
    .en_strobe (settled_r),
    .level     (chan_a_s.level),
    .rise      (chan_a_s.rise)
  );

  debounce_chan #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .CNT_W           (CNT_W)
  ) u_chan_b (
    .clk       (clk),
    .rst_n     (rst_n),
    .raw       (b_raw),
    .en_strobe (settled_r),
    .level     (chan_b_s.level),
    .rise      (chan_b_s.rise)
  );

  assign a       = chan_a_s.level;
  assign a_rise  = chan_a_s.rise;
  assign b       = chan_b_s.level;
  assign b_rise  = chan_b_s.rise;
  assign settled = settled_r;

endmodule

// File: tb/tb_ab_input_conditioner.sv
// Randomized and directed bench for ab_input_conditioner, checked against a
// window-based reference model of the debounce and startup rules.
module tb_ab_input_conditioner;

  localparam int D  = 4;
  localparam int CW = 8;

  logic clk;
  logic rst_n;
  logic a_raw;
  logic b_raw;
  logic a;
  logic b;
  logic a_rise;
  logic b_rise;
  logic settled;

  int checks;
  int errors;

  // reference model state
  bit hist[2][$];
  bit m_out[2];
  bit m_rise[2];
  bit m_settled;
  int m_edges;

  ab_input_conditioner #(
    .DEBOUNCE_CYCLES (D),
    .CNT_W           (CW)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .a_raw   (a_raw),
    .b_raw   (b_raw),
    .a       (a),
    .b       (b),
    .a_rise  (a_rise),
    .b_rise  (b_rise),
    .settled (settled)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    hist[0].delete();
    hist[1].delete();
    m_out     = '{1'b0, 1'b0};
    m_rise    = '{1'b0, 1'b0};
    m_settled = 1'b0;
    m_edges   = 0;
  endtask

  // An output flips once the last D synchronized samples (raw delayed two
  // edges, zero before release) all disagree with it.
  task automatic model_step(input bit ra, input bit rb);
    bit was_settled;
    bit all_diff;
    bit v;
    int idx;
    m_edges++;
    hist[0].push_back(ra);
    hist[1].push_back(rb);
    was_settled = m_settled;
    for (int ch = 0; ch < 2; ch++) begin
      all_diff = 1'b1;
      for (int k = 0; k < D; k++) begin
        idx = hist[ch].size() - 3 - k;
        v = (idx >= 0) ? hist[ch][idx] : 1'b0;
        if (v == m_out[ch]) all_diff = 1'b0;
      end
      m_rise[ch] = 1'b0;
      if (all_diff) begin
        m_out[ch]  = ~m_out[ch];
        m_rise[ch] = m_out[ch] & was_settled;
      end
    end
    if (m_edges >= D + 2) m_settled = 1'b1;
  endtask

  task automatic check_all(input string ph);
    chk({ph, ".a"},       32'(a),       32'(m_out[0]));
    chk({ph, ".b"},       32'(b),       32'(m_out[1]));
    chk({ph, ".a_rise"},  32'(a_rise),  32'(m_rise[0]));
    chk({ph, ".b_rise"},  32'(b_rise),  32'(m_rise[1]));
    chk({ph, ".settled"}, 32'(settled), 32'(m_settled));
  endtask

  task automatic cycle(input bit ra, input bit rb, input string ph);
    a_raw = ra;
    b_raw = rb;
    @(posedge clk);
    model_step(ra, rb);
    #1;
    check_all(ph);
  endtask

  task automatic check_zero(input string ph);
    chk({ph, ".a"},       32'(a),       32'd0);
    chk({ph, ".b"},       32'(b),       32'd0);
    chk({ph, ".a_rise"},  32'(a_rise),  32'd0);
    chk({ph, ".b_rise"},  32'(b_rise),  32'd0);
    chk({ph, ".settled"}, 32'(settled), 32'd0);
  endtask

  // Asserts reset mid-cycle, holds it for n edges, releases at a falling edge.
  task automatic do_reset(input bit ra, input bit rb, input int n, input string ph);
    a_raw = ra;
    b_raw = rb;
    #2;
    rst_n = 1'b0;
    #1;
    check_zero({ph, ".async"});
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      check_zero({ph, ".held"});
    end
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  initial begin
    int first_set;
    int first_a;
    int a_rises;
    int b_rises;
    int hold[2];
    bit val[2];

    checks = 0;
    errors = 0;
    rst_n  = 1'b1;
    a_raw  = 1'b0;
    b_raw  = 1'b0;
    model_reset();
    @(posedge clk);
    #1;

    // 1: reset with raw low, settled on 6th edge
    do_reset(1'b0, 1'b0, 2, "t1rst");
    first_set = -1;
    for (int i = 1; i <= 8; i++) begin
      cycle(1'b0, 1'b0, "t1");
      if (settled && first_set < 0) first_set = i;
    end
    chk("t1.settle_edge", 32'(first_set), 32'd6);

    // 2: a rises, latency D+1 edges from capture, single strobe
    first_a = -1;
    a_rises = 0;
    for (int i = 1; i <= 9; i++) begin
      cycle(1'b1, 1'b0, "t2");
      if (a && first_a < 0) first_a = i;
      if (a_rise) a_rises++;
    end
    chk("t2.a_edge", 32'(first_a), 32'd6);
    chk("t2.a_rise_count", 32'(a_rises), 32'd1);

    // 5a: a falls, no strobe
    first_a = -1;
    a_rises = 0;
    for (int i = 1; i <= 9; i++) begin
      cycle(1'b0, 1'b0, "t5fall");
      if (!a && first_a < 0) first_a = i;
      if (a_rise) a_rises++;
    end
    chk("t5.fall_edge", 32'(first_a), 32'd6);
    chk("t5.fall_rise_count", 32'(a_rises), 32'd0);

    // 3: 3-cycle pulses are rejected
    a_rises = 0;
    for (int r = 0; r < 10; r++) begin
      for (int i = 0; i < 3; i++) begin
        cycle(1'b1, 1'b0, "t3");
        if (a || a_rise) a_rises++;
      end
      for (int i = 0; i < 3; i++) begin
        cycle(1'b0, 1'b0, "t3");
        if (a || a_rise) a_rises++;
      end
    end
    chk("t3.glitch_seen", 32'(a_rises), 32'd0);

    // 4: simultaneous rise on both channels
    a_rises = 0;
    b_rises = 0;
    for (int i = 1; i <= 9; i++) begin
      cycle(1'b1, 1'b1, "t4");
      if (a_rise && b_rise) a_rises++;
      if (a_rise != b_rise) b_rises++;
    end
    chk("t4.joint_rise", 32'(a_rises), 32'd1);
    chk("t4.split_rise", 32'(b_rises), 32'd0);
    for (int i = 0; i < 9; i++) cycle(1'b0, 1'b0, "t4fall");

    // 5b: reset partway into a new debounce
    cycle(1'b1, 1'b0, "t5mid");
    cycle(1'b1, 1'b0, "t5mid");
    do_reset(1'b1, 1'b0, 2, "t5rst");
    for (int i = 0; i < 10; i++) cycle(1'b0, 1'b0, "t5post");

    // 6: raw held high through reset release
    do_reset(1'b1, 1'b1, 2, "t6rst");
    first_set = -1;
    first_a   = -1;
    a_rises   = 0;
    for (int i = 1; i <= 9; i++) begin
      cycle(1'b1, 1'b1, "t6");
      if (settled && first_set < 0) first_set = i;
      if (a && first_a < 0) first_a = i;
      if (a_rise) a_rises++;
    end
    chk("t6.a_edge", 32'(first_a), 32'd6);
    chk("t6.settle_edge", 32'(first_set), 32'd6);
    chk("t6.a_rise_count", 32'(a_rises), 32'd0);

    // random bouncing on both channels
    hold = '{0, 0};
    val  = '{1'b1, 1'b1};
    for (int i = 0; i < 500; i++) begin
      for (int ch = 0; ch < 2; ch++) begin
        if (hold[ch] == 0) begin
          val[ch]  = 1'($urandom_range(0, 1));
          hold[ch] = int'($urandom_range(1, 8));
        end
        hold[ch]--;
      end
      cycle(val[0], val[1], "rnd");
      if (i == 250) begin
        do_reset(val[0], val[1], 1, "rndrst");
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
